// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: controller states, datapath ops
// and direction encoding.
package usr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } usr_state_e;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_LOAD  = 2'd1,
    OP_SHIFT = 2'd2
  } core_op_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_core.sv
// WIDTH-bit datapath of the universal shift register: hold, parallel load,
// and one-position left/right shift with optional circular fill.
module shift_core
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  core_op_e         i_op,
  input  logic [WIDTH-1:0] i_par_in,
  input  logic             i_dir,
  input  logic             i_rotate,
  input  logic             i_serial_r,
  input  logic             i_serial_l,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;
  logic             w_fill_msb;
  logic             w_fill_lsb;

  // When rotating, the bit leaving one end replaces the serial input at the other.
  always_comb begin
    w_fill_msb = i_rotate ? r_q[0]       : i_serial_r;
    w_fill_lsb = i_rotate ? r_q[WIDTH-1] : i_serial_l;
    w_next     = r_q;
    case (i_op)
      OP_LOAD: w_next = i_par_in;
      OP_SHIFT: begin
        if (i_dir == DIR_RIGHT) begin
          w_next = {w_fill_msb, r_q[WIDTH-1:1]};
        end else begin
          w_next = {r_q[WIDTH-2:0], w_fill_lsb};
        end
      end
      default: w_next = r_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_clear) begin
    if (i_clear) begin
      r_q <= '0;
    end else begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: parallel load plus counted left/right shift bursts.
// Define USR_ROTATE_EN to honour the rotate request; otherwise rotate is ignored.
module universal_shift_reg
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_par_in,
  input  logic             i_start,
  input  logic             i_dir,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_serial_r,
  input  logic             i_serial_l,
  input  logic             i_rotate,
  output logic [WIDTH-1:0] o_q,
  output logic             o_out,
  output logic             o_busy,
  output logic             o_done
);

`ifdef USR_ROTATE_EN
  localparam logic ROTATE_EN = 1'b1;
`else
  localparam logic ROTATE_EN = 1'b0;
`endif

  usr_state_e       r_state;
  logic             r_dir;
  logic             r_rotate;
  logic [CNT_W-1:0] r_count;
  core_op_e         w_op;
  logic             w_rotate_req;
  logic [WIDTH-1:0] w_q;

  // With the feature disabled the latched rotate flag is forced to zero.
  assign w_rotate_req = i_rotate & ROTATE_EN;

  always_ff @(posedge i_clk or posedge i_clear) begin
    if (i_clear) begin
      r_state  <= IDLE;
      r_dir    <= DIR_LEFT;
      r_rotate <= 1'b0;
      r_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!i_load && i_start) begin
            r_dir    <= i_dir;
            r_rotate <= w_rotate_req;
            r_count  <= i_len;
            r_state  <= (i_len != '0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          r_count <= r_count - CNT_W'(1);
          if (r_count == CNT_W'(1)) begin
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Load only counts in IDLE; requests during a burst or its DONE cycle are dropped.
  always_comb begin
    w_op = OP_HOLD;
    if (r_state == IDLE && i_load) begin
      w_op = OP_LOAD;
    end else if (r_state == SHIFT) begin
      w_op = OP_SHIFT;
    end
  end

  shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_clk      (i_clk),
    .i_clear    (i_clear),
    .i_op       (w_op),
    .i_par_in   (i_par_in),
    .i_dir      (r_dir),
    .i_rotate   (r_rotate),
    .i_serial_r (i_serial_r),
    .i_serial_l (i_serial_l),
    .o_q        (w_q)
  );

  assign o_q    = w_q;
  assign o_out  = (r_dir == DIR_RIGHT) ? w_q[0] : w_q[WIDTH-1];
  assign o_busy = (r_state == SHIFT);
  assign o_done = (r_state == DONE);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed testbench for universal_shift_reg at WIDTH=8; honours USR_ROTATE_EN
// when choosing the expected rotate result.
module tb_universal_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] parIn;
  logic             start;
  logic             dir;
  logic [CNT_W-1:0] len;
  logic             serialR;
  logic             serialL;
  logic             rotate;
  logic [WIDTH-1:0] q;
  logic             out;
  logic             busy;
  logic             done;

  int vectors;
  int miscompares;

  universal_shift_reg #(
    .WIDTH (WIDTH)
  ) dut (
    .i_clk      (clk),
    .i_clear    (clear),
    .i_load     (load),
    .i_par_in   (parIn),
    .i_start    (start),
    .i_dir      (dir),
    .i_len      (len),
    .i_serial_r (serialR),
    .i_serial_l (serialL),
    .i_rotate   (rotate),
    .o_q        (q),
    .o_out      (out),
    .o_busy     (busy),
    .o_done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ld, input logic [WIDTH-1:0] pd,
                               input logic st, input logic d,
                               input logic [CNT_W-1:0] n, input logic rot);
    load   = ld;
    parIn  = pd;
    start  = st;
    dir    = d;
    len    = n;
    rotate = rot;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({q, out, busy, done} !== 11'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_initial: got q=%h out=%b busy=%b done=%b, need all 0", q, out, busy, done);
    end
    tick();
    clear = 1'b0;
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 4'd3, 1'b0);
    tick();
    start = 1'b0;
    #2;
    clear = 1'b1;
    #1;
    vectors++;
    if ({q, out, busy, done} !== 11'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_midcycle: got q=%h out=%b busy=%b done=%b, need all 0", q, out, busy, done);
    end
    tick();
    clear = 1'b0;
  endtask

  task automatic test_shift_right();
    logic [WIDTH-1:0] expQ [4] = '{8'h52, 8'h29, 8'h14, 8'h0A};
    logic             expOut [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int busyCycles = 0;
    int donePulses = 0;
    serialR = 1'b0;
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    vectors++;
    if (q !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL load_a5: got %h, need a5", q);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 4'd4, 1'b0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busy === 1'b1) busyCycles++;
      if (done === 1'b1) donePulses++;
      tick();
      vectors++;
      if (q !== expQ[i] || out !== expOut[i]) begin
        miscompares++;
        $display("[TB] FAIL right_shift_%0d: got q=%h out=%b, need q=%h out=%b", i, q, out, expQ[i], expOut[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (busy === 1'b1) busyCycles++;
      if (done === 1'b1) donePulses++;
      tick();
    end
    vectors++;
    if (busyCycles !== 4 || donePulses !== 1) begin
      miscompares++;
      $display("[TB] FAIL right_burst_counts: got busy=%0d done=%0d, need busy=4 done=1", busyCycles, donePulses);
    end
  endtask

  task automatic test_shift_left_fill();
    logic [WIDTH-1:0] expQ [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    serialL = 1'b1;
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 4'd8, 1'b0);
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (q !== expQ[i]) begin
        miscompares++;
        $display("[TB] FAIL left_fill_%0d: got q=%h, need %h", i, q, expQ[i]);
      end
    end
    vectors++;
    if (out !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL left_fill_done: got out=%b done=%b busy=%b, need 1 1 0", out, done, busy);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || out !== 1'b1 || q !== 8'hFF) begin
      miscompares++;
      $display("[TB] FAIL left_fill_after: got done=%b out=%b q=%h, need 0 1 ff", done, out, q);
    end
    serialL = 1'b0;
  endtask

  task automatic test_len_zero();
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 4'd0, 1'b0);
    tick();
    start = 1'b0;
    vectors++;
    if (q !== 8'h3C || busy !== 1'b0 || done !== 1'b1 || out !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL len_zero_done: got q=%h busy=%b done=%b out=%b, need 3c 0 1 0", q, busy, done, out);
    end
    tick();
    vectors++;
    if (q !== 8'h3C || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL len_zero_after: got q=%h busy=%b done=%b, need 3c 0 0", q, busy, done);
    end
  endtask

  task automatic test_clear_mid_burst();
    int donePulses = 0;
    serialR = 1'b1;
    applyStimulus(1'b1, 8'hF0, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 4'd6, 1'b0);
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    clear = 1'b1;
    #1;
    vectors++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || out !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL clear_mid_burst: got q=%h busy=%b done=%b out=%b, need 00 0 0 0", q, busy, done, out);
    end
    tick();
    clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) donePulses++;
    end
    vectors++;
    if (donePulses !== 0) begin
      miscompares++;
      $display("[TB] FAIL clear_no_done: got %0d busy/done cycles, need 0", donePulses);
    end
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    load = 1'b0;
    vectors++;
    if (q !== 8'h55) begin
      miscompares++;
      $display("[TB] FAIL clear_then_load: got q=%h, need 55", q);
    end
    serialR = 1'b0;
  endtask

  task automatic test_ignore_requests();
    serialR = 1'b0;
    applyStimulus(1'b1, 8'h0F, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 4'd2, 1'b0);
    tick();
    applyStimulus(1'b1, 8'hFF, 1'b1, 1'b0, 4'd5, 1'b0);
    tick();
    vectors++;
    if (q !== 8'h07 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ignore_in_shift: got q=%h busy=%b, need 07 1", q, busy);
    end
    tick();
    vectors++;
    if (q !== 8'h03 || done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ignore_in_done_entry: got q=%h done=%b, need 03 1", q, done);
    end
    tick();
    vectors++;
    if (q !== 8'h03 || done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ignore_in_done: got q=%h done=%b busy=%b, need 03 0 0", q, done, busy);
    end
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    vectors++;
    if (q !== 8'hFF || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL load_priority: got q=%h busy=%b done=%b, need ff 0 0", q, busy, done);
    end
  endtask

  task automatic test_rotate();
    logic [WIDTH-1:0] expQ;
`ifdef USR_ROTATE_EN
    expQ = 8'h03;
`else
    expQ = 8'h02;
`endif
    serialL = 1'b0;
    applyStimulus(1'b1, 8'h81, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 4'd1, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    tick();
    vectors++;
    if (q !== expQ || done !== 1'b1 || out !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rotate_left: got q=%h done=%b out=%b, need %h 1 0", q, done, out, expQ);
    end
    tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clear   = 1'b1;
    serialR = 1'b0;
    serialL = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0);
    test_reset();
    test_shift_right();
    test_shift_left_fill();
    test_len_zero();
    test_clear_mid_burst();
    test_ignore_requests();
    test_rotate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
